map_port_arbiter: RTL and testbench

Shares the single-port world-map block RAM between the VGA display path and the Rojobot sensor/location query path. Each cycle it grants at most one RAM read. It returns the display read as a 12-bit palette colour aligned for the icon/map colorizer stage, and returns the bot read as raw 2-bit map data with an acknowledge. Three mechanisms keep the bot from starving:
- a repeated-address bypass on the video side;
- a wait-count override;
- stale-pixel substitution on the video side when the override fires.

---
 rtl/rojobot_map_pkg.sv | 32 +++
 rtl/map_palette.sv | 30 +++
 rtl/map_port_arbiter.sv | 127 ++++++++++++
 tb/tb_map_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rojobot_map_pkg.sv
// Shared types and constants for the world-map RAM port arbiter and its palette.
// Imported by every map-path module so tag encodings and defaults stay in one place.
package rojobot_map_pkg;

    localparam int MAP_ADDR_W = 14;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_BOT  = 2'd2,
        TAG_PASS = 2'd3
    } tag_e;

    localparam logic [1:0] MAP_BG   = 2'd0;
    localparam logic [1:0] MAP_LINE = 2'd1;
    localparam logic [1:0] MAP_OBST = 2'd2;
    localparam logic [1:0] MAP_RSVD = 2'd3;

    localparam logic [11:0] PAL_BG_DEF   = 12'hFFF;
    localparam logic [11:0] PAL_LINE_DEF = 12'h000;
    localparam logic [11:0] PAL_OBST_DEF = 12'hF00;
    localparam logic [11:0] PAL_RSVD_DEF = 12'h0F0;

    // A HIT/STALE pixel and a bot read can share one slot, so each stage keeps
    // a video lane (NONE/VID/PASS) and a bot lane (NONE/BOT).
    typedef struct packed {
        tag_e vid_tag;
        tag_e bot_tag;
        logic stale;
    } stage_t;

endpackage

// File: rtl/map_palette.sv
// Registered 2-bit map value to 12-bit colour lookup; colour holds unless load is set.
module map_palette
    import rojobot_map_pkg::*;
#(
    parameter logic [11:0] PAL0 = PAL_BG_DEF,
    parameter logic [11:0] PAL1 = PAL_LINE_DEF,
    parameter logic [11:0] PAL2 = PAL_OBST_DEF,
    parameter logic [11:0] PAL3 = PAL_RSVD_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [1:0]  idx,
    output logic [11:0] color
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            color <= 12'h000;
        end else if (load) begin
            case (idx)
                MAP_BG:   color <= PAL0;
                MAP_LINE: color <= PAL1;
                MAP_OBST: color <= PAL2;
                default:  color <= PAL3;
            endcase
        end
    end

endmodule

// File: rtl/map_port_arbiter.sv
// Arbitrates the single-port world-map RAM between the video pixel fetch and
// Rojobot queries, with HIT bypass, starvation override and stale-pixel repeat.
module map_port_arbiter
    import rojobot_map_pkg::*;
#(
    parameter int          ADDR_W     = MAP_ADDR_W,
    parameter int          STARVE_MAX = 8,
    parameter logic [11:0] PAL0       = PAL_BG_DEF,
    parameter logic [11:0] PAL1       = PAL_LINE_DEF,
    parameter logic [11:0] PAL2       = PAL_OBST_DEF,
    parameter logic [11:0] PAL3       = PAL_RSVD_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic              vid_stale,
    output logic [11:0]       map_color,
    input  logic              bot_req,
    input  logic [ADDR_W-1:0] bot_addr,
    output logic              bot_ack,
    output logic [1:0]        bot_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_dout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(STARVE_MAX - 1);

    logic [7:0]        wait_cnt;
    logic              last_vld;
    logic [ADDR_W-1:0] last_vaddr;
    stage_t            stage1;
    stage_t            stage2;

    logic   bot_busy;
    logic   vid_hit;
    logic   vid_new;
    logic   bot_pend;
    logic   override;
    logic   grant_vid;
    logic   grant_bot;
    stage_t slot;

    // The bot counts as busy until its ack cycle is over, so a level request
    // still high during ack is not granted twice.
    assign bot_busy  = (stage1.bot_tag == TAG_BOT) || (stage2.bot_tag == TAG_BOT) || bot_ack;
    assign vid_hit   = vid_req && last_vld && (vid_addr == last_vaddr);
    assign vid_new   = vid_req && !vid_hit;
    assign bot_pend  = bot_req && !bot_busy;
    assign override  = bot_pend && (wait_cnt == WAIT_LIMIT);
    assign grant_vid = vid_new && !override;
    assign grant_bot = bot_pend && (!vid_new || override);

    always_comb begin
        slot = '{vid_tag: TAG_NONE, bot_tag: TAG_NONE, stale: 1'b0};
        if (grant_vid) begin
            slot.vid_tag = TAG_VID;
        end else if (vid_req) begin
            slot.vid_tag = TAG_PASS;
            slot.stale   = vid_new;
        end
        if (grant_bot) begin
            slot.bot_tag = TAG_BOT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            stage1     <= '{vid_tag: TAG_NONE, bot_tag: TAG_NONE, stale: 1'b0};
            stage2     <= '{vid_tag: TAG_NONE, bot_tag: TAG_NONE, stale: 1'b0};
            vid_valid  <= 1'b0;
            vid_stale  <= 1'b0;
            bot_ack    <= 1'b0;
            bot_data   <= 2'd0;
            wait_cnt   <= 8'd0;
            last_vld   <= 1'b0;
            last_vaddr <= '0;
        end else begin
            mem_en <= grant_vid || grant_bot;
            if (grant_vid) begin
                mem_addr <= vid_addr;
            end else if (grant_bot) begin
                mem_addr <= bot_addr;
            end

            stage1 <= slot;
            stage2 <= stage1;

            vid_valid <= (stage2.vid_tag != TAG_NONE);
            vid_stale <= (stage2.vid_tag == TAG_PASS) && stage2.stale;
            bot_ack   <= (stage2.bot_tag == TAG_BOT);
            if (stage2.bot_tag == TAG_BOT) begin
                bot_data <= mem_dout;
            end

            if (grant_vid) begin
                last_vld   <= 1'b1;
                last_vaddr <= vid_addr;
            end

            // Only a request that is actually waiting ages; in-flight cycles do not.
            if (!bot_pend || grant_bot) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    map_palette #(
        .PAL0 (PAL0),
        .PAL1 (PAL1),
        .PAL2 (PAL2),
        .PAL3 (PAL3)
    ) u_palette (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (stage2.vid_tag == TAG_VID),
        .idx     (mem_dout),
        .color   (map_color)
    );

endmodule

// File: tb/tb_map_port_arbiter.sv
// Scoreboard bench for map_port_arbiter: expected pixels and bot replies are queued
// when driven and compared (value and arrival cycle) when the DUT produces them.
module tb_map_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [13:0] vid_addr;
    logic        vid_valid;
    logic        vid_stale;
    logic [11:0] map_color;
    logic        bot_req;
    logic [13:0] bot_addr;
    logic        bot_ack;
    logic [1:0]  bot_data;
    logic        mem_en;
    logic [13:0] mem_addr;
    logic [1:0]  mem_dout = 2'd0;

    logic [1:0]  ram [0:16383];

    typedef struct {
        logic [11:0] color;
        logic        stale;
        int          cyc;
    } vexp_t;

    typedef struct {
        logic [1:0] data;
        int         cyc;
    } bexp_t;

    vexp_t       vq[$];
    bexp_t       bq[$];
    logic [13:0] memq[$];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ack_cnt = 0;
    logic [11:0] last_color;

    map_port_arbiter #(.STARVE_MAX(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_valid (vid_valid),
        .vid_stale (vid_stale),
        .map_color (map_color),
        .bot_req   (bot_req),
        .bot_addr  (bot_addr),
        .bot_ack   (bot_ack),
        .bot_data  (bot_data),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) mem_dout <= ram[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [11:0] pal(input logic [1:0] v);
        case (v)
            2'd0:    return 12'hFFF;
            2'd1:    return 12'h000;
            2'd2:    return 12'hF00;
            default: return 12'h0F0;
        endcase
    endfunction

    // Output monitor: pops the scoreboard whenever the DUT produces a result.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_en) memq.push_back(mem_addr);
            if (vid_valid) begin
                if (vq.size() == 0) begin
                    check_val("vid_unexpected", 32'd1, 32'd0);
                end else begin
                    vexp_t e;
                    e = vq.pop_front();
                    check_val("vid_color", 32'(map_color), 32'(e.color));
                    check_val("vid_stale", 32'(vid_stale), 32'(e.stale));
                    check_val("vid_cycle", 32'(cyc), 32'(e.cyc));
                    $display("pixel  cyc=%0d color=%03h stale=%0d", cyc, map_color, vid_stale);
                end
            end
            if (bot_ack) begin
                ack_cnt++;
                if (bq.size() == 0) begin
                    check_val("bot_unexpected", 32'd1, 32'd0);
                end else begin
                    bexp_t b;
                    b = bq.pop_front();
                    check_val("bot_data", 32'(bot_data), 32'(b.data));
                    check_val("bot_cycle", 32'(cyc), 32'(b.cyc));
                    $display("botack cyc=%0d data=%0d", cyc, bot_data);
                end
            end
        end
    end

    task automatic step(input logic vr, input logic [13:0] va, input logic br, input logic [13:0] ba);
        @(posedge clk);
        #1;
        vid_req  = vr;
        vid_addr = va;
        bot_req  = br;
        bot_addr = ba;
    endtask

    task automatic push_vid(input logic [13:0] a, input logic stale, input int c);
        vexp_t e;
        e.color    = stale ? last_color : pal(ram[a]);
        e.stale    = stale;
        e.cyc      = c;
        last_color = e.color;
        vq.push_back(e);
    endtask

    task automatic push_bot(input logic [13:0] a, input int c);
        bexp_t b;
        b.data = ram[a];
        b.cyc  = c;
        bq.push_back(b);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 6; i++) step(1'b0, 14'd0, 1'b0, 14'd0);
        check_val({tag, "_vid_left"}, 32'(vq.size()), 32'd0);
        check_val({tag, "_bot_left"}, 32'(bq.size()), 32'd0);
        vq.delete();
        bq.delete();
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check_val({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_val({tag, "_vid_valid"}, 32'(vid_valid), 32'd0);
        check_val({tag, "_vid_stale"}, 32'(vid_stale), 32'd0);
        check_val({tag, "_map_color"}, 32'(map_color), 32'h000);
        check_val({tag, "_bot_ack"}, 32'(bot_ack), 32'd0);
        check_val({tag, "_bot_data"}, 32'(bot_data), 32'd0);
    endtask

    initial begin
        logic [13:0] a;
        int          acks_before;

        for (int i = 0; i < 16384; i++) ram[i] = 2'(i % 4);
        ram[100] = 2'd2;
        reset_n  = 1'b0;
        vid_req  = 1'b0;
        vid_addr = 14'd0;
        bot_req  = 1'b0;
        bot_addr = 14'd0;
        last_color = 12'h000;

        repeat (2) @(posedge clk);
        #2;
        check_reset("rst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Repeated-address bypass: 5,5,5,5,6 reads RAM twice.
        memq.delete();
        for (int k = 0; k < 5; k++) begin
            a = (k < 4) ? 14'd5 : 14'd6;
            step(1'b1, a, 1'b0, 14'd0);
            push_vid(a, 1'b0, cyc + 3);
        end
        drain("bypass");
        check_val("bypass_rd_count", 32'(memq.size()), 32'd2);
        if (memq.size() == 2) begin
            check_val("bypass_rd0", 32'(memq[0]), 32'd5);
            check_val("bypass_rd1", 32'(memq[1]), 32'd6);
        end

        // Lone bot read, video idle.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 14'd0, 1'b1, 14'd100);
            if (k == 0) push_bot(14'd100, cyc + 3);
        end
        drain("bot_alone");

        // Video streams new addresses; bot overrides on its 8th waiting cycle,
        // then a held request is served as a fresh one with a fresh wait count.
        for (int k = 0; k < 24; k++) begin
            a = (k == 8) ? 14'd307 : 14'(300 + k);
            step(1'b1, a, k <= 21, (k <= 10) ? 14'd401 : 14'd402);
            push_vid(a, (k == 7) || (k == 18), cyc + 3);
            if (k == 0)  push_bot(14'd401, cyc + 10);
            if (k == 11) push_bot(14'd402, cyc + 10);
        end
        drain("starve");

        // Each address repeated 4x: bot takes the first HIT slot, no stale pixels.
        for (int k = 0; k < 12; k++) begin
            a = 14'(500 + k / 4);
            step(1'b1, a, k <= 4, 14'd402);
            push_vid(a, 1'b0, cyc + 3);
            if (k == 0) push_bot(14'd402, cyc + 4);
        end
        drain("hitshare");

        // Reset asserted mid-cycle while a bot read is in flight.
        acks_before = ack_cnt;
        step(1'b0, 14'd0, 1'b1, 14'd100);
        step(1'b0, 14'd0, 1'b1, 14'd100);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        bot_req = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drain("midrst");
        check_val("midrst_no_ack", 32'(ack_cnt - acks_before), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
